i2c_target: RTL and testbench
=============================

# i2c_target

Serial responder for the I2C link driven by `i2cController`. It decodes each frame arriving on `scl`/`sda`, acknowledges it, and turns it into one single-cycle write or read on the memory-side port. The block sits between the I2C bus and the memory controller. It replaces the acknowledge model the controller bench uses today.

## Interface
Parameters:
- `DATAWIDTH`, 8, data byte width (from `i2c_pkg`).
- `ADDRWIDTH`, 6, memory address width (from `i2c_pkg`).

Ports:
- `clk`  in  1  system clock; samples the bus.
- `reset`  in  1  reset, asynchronous, active-low.
- `scl`  in  1  bus clock; the target never drives it.
- `sda`  inout  1  open-drain data; the target drives only `1'b0`, otherwise `'z`.
- `mem_addr`  out  ADDRWIDTH  address latched from the header.
- `mem_wdata`  out  DATAWIDTH  write byte.
- `mem_wr_en`  out  1  one-cycle write strobe.
- `mem_rd_en`  out  1  one-cycle read strobe.
- `mem_rdata`  in  DATAWIDTH  read data, valid 1 `clk` after `mem_rd_en`.
- `busy`  out  1  high from START until STOP.

## Operation
- Frame format, MSB first:
  - START.
  - Header: 7 bits, `addr[5:0]` then R/W (1 = read).
  - Target ACK.
  - 8 data bits.
  - Data ACK: on a write the target drives it; on a read the controller drives it (value ignored).
  - STOP.
- Bus events:
  - START = `sda` falls while `scl` high.
  - STOP = `sda` rises while `scl` high.
  - Bits are sampled on a detected `scl` rise.
  - The target changes `sda` only after a detected `scl` fall.
- States: IDLE, HDR, HDR_ACK, WDATA, WACK, RDATA, RACK, WAIT_STOP.
  - IDLE -> HDR on START; bit counter cleared.
  - HDR -> HDR_ACK after the 7th bit; `mem_addr` latched.
  - HDR_ACK: drive `sda` low for one `scl` period, then go to WDATA (R/W = 0) or RDATA (R/W = 1).
  - WDATA -> WACK after 8 bits; `mem_wdata` and `mem_wr_en` issued; WACK drives ACK.
  - WACK -> WAIT_STOP on the `scl` fall that ends the ACK.
  - RDATA: shift the captured `mem_rdata` out MSB first, driving low for each 0 bit and releasing for each 1 bit.
  - RDATA -> RACK after 8 bits; `sda` released. RACK -> WAIT_STOP.
- START in any state, including a repeated start, goes to HDR and aborts the frame. No memory strobe is issued for an incomplete frame.
- STOP in any state goes to IDLE, releases `sda` and drops `busy`.
- Bit counter is 3 bits and saturates; it never wraps into a second byte.
- One data byte per frame. Bits seen in WAIT_STOP are ignored.
- Reset mid-frame: outputs go to reset values at once and `sda` is released.
- Reset values: `sda` = `'z`, `mem_addr` = 0, `mem_wdata` = 0, `mem_wr_en` = 0, `mem_rd_en` = 0, `busy` = 0, state = IDLE.

## Timing
- Input path: 2-flop synchronizer, then an edge detect. A pin change is seen as an event 3 `clk` after it occurs.
- `mem_rd_en` pulses the `clk` after the R/W bit is sampled as 1. `mem_rdata` is captured on the next `clk`, well before the first RDATA bit is driven.
- `mem_wr_en` pulses the `clk` after the 8th data bit is sampled. `mem_addr` and `mem_wdata` are stable in that cycle and stay held until the next frame.
- `sda` updates 1 `clk` after a detected `scl` fall.
- Bus requirement: `scl` high and low phases each ≥ 4 `clk` (≥ 7 with the filter enabled). `sda` must not change while `scl` is high, except for START and STOP.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN` defined:
  - 3-sample majority filter on synchronized `scl` and `sda`.
  - Pulses shorter than 2 `clk` are rejected.
  - Event latency becomes 6 `clk`.
- Undefined: no filter; 3-`clk` latency.

## Structure
- `i2c_pkg` holds:
  - `DATAWIDTH` and `ADDRWIDTH`.
  - `typedef enum` `i2c_target_state_t`.
  - `localparam HDR_BITS = ADDRWIDTH+1`.
- Sub-module `i2c_line_sync`: synchronizer, optional filter and rise/fall detect. Instantiated once for `scl` and once for `sda`.

## Test plan
- Write: frame addr 6'h2A, data 8'hC3 -> ACK low after header and after data; one `mem_wr_en` pulse with `mem_addr` = 6'h2A, `mem_wdata` = 8'hC3.
- Read: addr 6'h05, `mem_rdata` = 8'h96 -> `mem_rd_en` pulses once with `mem_addr` = 6'h05; controller samples 10010110 on `sda`.
- Repeated START after 4 header bits, then a full write to 6'h11 with 8'h7E -> only one `mem_wr_en` pulse, for 6'h11/8'h7E.
- `reset` asserted during WDATA bit 5 -> `sda` is `'z`, `busy` = 0 and no strobe occurs; the next full frame completes normally.
- STOP during RDATA -> `sda` released within 4 `clk`; `busy` falls; state is IDLE.
- With `I2C_TARGET_GLITCH_FILTER_EN` defined: 1-`clk` low glitch on `sda` while `scl` high -> no START or STOP detected; without the macro the glitch is seen as START.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, FSM state encoding and small helpers for the
// I2C target that answers frames from i2cController.
package i2c_pkg;

  localparam int DATAWIDTH = 8;
  localparam int ADDRWIDTH = 6;
  localparam int HDR_BITS  = ADDRWIDTH + 1;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HDR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } i2c_target_state_t;

  // Bit counter increment that sticks at all-ones instead of wrapping,
  // so a runaway bus can never start a second byte.
  function automatic logic [BIT_CNT_W-1:0] cnt_sat_inc(input logic [BIT_CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings one bus pin into the clk domain and reports its
// level plus rise/fall strobes. Optional build macro
// I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter that
// swallows pulses shorter than 2 clk, at the cost of 3 extra clk latency.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic filt;

  // Two-flop synchronizer; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] hist_q;
  logic       filt_q;

  // Majority vote over the last three synchronized samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 3'b111;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[1:0], sync2_q};
      filt_q <= (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                (hist_q[1] & hist_q[2]);
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  // Previous filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= filt;
    end
  end

  assign level = filt;
  assign rise  = filt & ~prev_q;
  assign fall  = ~filt & prev_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: single-byte I2C responder. Each frame (START, 6-bit address,
// R/W, ACK, one data byte, ACK, STOP) becomes one write or one read strobe
// on the memory port. Optional build macro I2C_TARGET_GLITCH_FILTER_EN
// enables the input glitch filter in i2c_line_sync.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | bus free, waiting for START
// ST_HDR       | shifting in address and R/W bits
// ST_HDR_ACK   | pulling sda low for the header ACK bit
// ST_WDATA     | shifting in the write byte
// ST_WACK      | pulling sda low for the data ACK bit
// ST_RDATA     | shifting the read byte out, MSB first
// ST_RACK      | sda released while controller drives its ACK/NACK
// ST_WAIT_STOP | frame complete, ignoring bits until STOP or START
module i2c_target
  import i2c_pkg::*;
#(
  parameter int DATAWIDTH = i2c_pkg::DATAWIDTH,
  parameter int ADDRWIDTH = i2c_pkg::ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl,
  inout  wire                  sda,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_target_state_t state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ack_on_q, ack_on_d;
  logic                 sda_low_q, sda_low_d;
  logic                 rw_q, rw_d;
  logic [DATAWIDTH-2:0] sr_q, sr_d;
  logic [DATAWIDTH-1:0] rd_sh_q, rd_sh_d;
  logic                 rd_cap_q;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;

  i2c_line_sync u_scl_sync (
    .clk   (clk),
    .rst_n (reset),
    .pin   (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk   (clk),
    .rst_n (reset),
    .pin   (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // Both lines pass through identical sync paths, so scl_lvl is aligned
  // with the sda edge it qualifies.
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ack_on_q  <= 1'b0;
      sda_low_q <= 1'b0;
      rw_q      <= 1'b0;
      sr_q      <= '0;
      rd_sh_q   <= '0;
      rd_cap_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_on_q  <= ack_on_d;
      sda_low_q <= sda_low_d;
      rw_q      <= rw_d;
      sr_q      <= sr_d;
      rd_sh_q   <= rd_sh_d;
      rd_cap_q  <= rd_en_q;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
    end
  end

  // Next-state and next-datapath decode; STOP outranks START, both outrank
  // the per-state bit handling. ACK states use ack_on to tell the scl fall
  // that begins the ACK bit from the one that ends it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_on_d  = ack_on_q;
    sda_low_d = sda_low_q;
    rw_d      = rw_q;
    sr_d      = sr_q;
    rd_sh_d   = rd_sh_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;

    // Read data is valid one clk after the read strobe.
    if (rd_cap_q) begin
      rd_sh_d = mem_rdata;
    end

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ST_HDR;
      cnt_d     = '0;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_HDR: begin
          if (scl_rise) begin
            sr_d  = {sr_q[DATAWIDTH-3:0], sda_lvl};
            cnt_d = cnt_sat_inc(cnt_q);
            if (cnt_q == BIT_CNT_W'(HDR_BITS - 1)) begin
              state_d = ST_HDR_ACK;
              addr_d  = sr_q[ADDRWIDTH-1:0];
              rw_d    = sda_lvl;
              rd_en_d = sda_lvl;
            end
          end
        end
        ST_HDR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_low_d = 1'b1;
              ack_on_d  = 1'b1;
            end else begin
              ack_on_d = 1'b0;
              cnt_d    = '0;
              if (rw_q) begin
                state_d   = ST_RDATA;
                sda_low_d = ~rd_sh_q[DATAWIDTH-1];
              end else begin
                state_d   = ST_WDATA;
                sda_low_d = 1'b0;
              end
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            sr_d  = {sr_q[DATAWIDTH-3:0], sda_lvl};
            cnt_d = cnt_sat_inc(cnt_q);
            if (cnt_q == BIT_CNT_W'(DATAWIDTH - 1)) begin
              state_d = ST_WACK;
              wdata_d = {sr_q, sda_lvl};
              wr_en_d = 1'b1;
            end
          end
        end
        ST_WACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_low_d = 1'b1;
              ack_on_d  = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              ack_on_d  = 1'b0;
              state_d   = ST_WAIT_STOP;
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_sat_inc(cnt_q);
            if (cnt_q == BIT_CNT_W'(DATAWIDTH - 1)) begin
              state_d = ST_RACK;
            end
          end else if (scl_fall) begin
            rd_sh_d   = {rd_sh_q[DATAWIDTH-2:0], 1'b0};
            sda_low_d = ~rd_sh_q[DATAWIDTH-2];
          end
        end
        ST_RACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_low_d = 1'b0;
              ack_on_d  = 1'b1;
            end else begin
              ack_on_d = 1'b0;
              state_d  = ST_WAIT_STOP;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr_en = wr_en_q;
  assign mem_rd_en = rd_en_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed frames against i2c_target with hand-computed
// expectations; acts as the bus controller and a one-cycle-latency memory.
module tb_i2c_target;

  localparam int H = 10;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int STOP_LAT = 7;
  localparam logic GLITCH_SEEN = 1'b0;
`else
  localparam int STOP_LAT = 4;
  localparam logic GLITCH_SEEN = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       ctl_low;
  wire        sda;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;
  logic [7:0] rd_value = 8'h96;

  int errs = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int busy_cyc = 0;
  logic [5:0] wr_addr = '0;
  logic [5:0] rd_addr = '0;
  logic [7:0] wr_data = '0;

  pullup (sda);
  assign sda = ctl_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory model: read data appears one clk after the strobe, for one clk.
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? rd_value : 8'h00;
  end

  // Strobe and busy monitors.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (mem_rd_en) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= mem_addr;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    ctl_low = 1'b0; clks(H);
    scl = 1'b1;     clks(H);
    ctl_low = 1'b1; clks(H);
    scl = 1'b0;     clks(2);
  endtask

  task automatic bus_stop();
    ctl_low = 1'b1; clks(H);
    scl = 1'b1;     clks(H);
    ctl_low = 1'b0; clks(H);
  endtask

  task automatic send_bit(input logic b);
    ctl_low = ~b; clks(H);
    scl = 1'b1;   clks(H);
    scl = 1'b0;   clks(2);
  endtask

  task automatic recv_bit(output logic b);
    ctl_low = 1'b0; clks(H);
    scl = 1'b1;     clks(H / 2);
    b = sda;        clks(H - H / 2);
    scl = 1'b0;     clks(2);
  endtask

  task automatic send_hdr(input logic [5:0] a, input logic rw);
    for (int i = 5; i >= 0; i--) send_bit(a[i]);
    send_bit(rw);
  endtask

  task automatic send_byte(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic write_frame(input logic [5:0] a, input logic [7:0] d,
                             output logic ack1, output logic ack2);
    bus_start();
    send_hdr(a, 1'b0);
    recv_bit(ack1);
    send_byte(d, 8);
    recv_bit(ack2);
    bus_stop();
  endtask

  task automatic read_frame(input logic [5:0] a, output logic ack1, output logic [7:0] d);
    logic b;
    bus_start();
    send_hdr(a, 1'b1);
    recv_bit(ack1);
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(1'b1);
    bus_stop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a1, a2, b;
    logic [7:0] d;
    int bc0;

    reset = 1'b0; scl = 1'b1; ctl_low = 1'b0;
    clks(5);
    check_val("rst_busy", busy, 0);
    check_val("rst_wr_en", mem_wr_en, 0);
    check_val("rst_rd_en", mem_rd_en, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_sda", sda, 1);
    reset = 1'b1;
    clks(5);

    // Plain write 2A <- C3.
    write_frame(6'h2A, 8'hC3, a1, a2);
    clks(5);
    check_val("wr_hdr_ack", a1, 0);
    check_val("wr_data_ack", a2, 0);
    check_val("wr_cnt", wr_cnt, 1);
    check_val("wr_addr", wr_addr, 6'h2A);
    check_val("wr_data", wr_data, 8'hC3);
    check_val("wr_hold_addr", mem_addr, 6'h2A);
    check_val("wr_hold_data", mem_wdata, 8'hC3);
    check_val("wr_busy_after", busy, 0);
    check_val("wr_no_rd", rd_cnt, 0);

    // Read from 05, memory returns 96.
    read_frame(6'h05, a1, d);
    clks(5);
    check_val("rd_hdr_ack", a1, 0);
    check_val("rd_byte", d, 8'h96);
    check_val("rd_cnt", rd_cnt, 1);
    check_val("rd_addr", rd_addr, 6'h05);
    check_val("rd_no_wr", wr_cnt, 1);

    // Repeated START after 4 header bits, then full write 11 <- 7E.
    bus_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check_val("rs_busy_mid", busy, 1);
    bus_start();
    send_hdr(6'h11, 1'b0);
    recv_bit(a1);
    send_byte(8'h7E, 8);
    recv_bit(a2);
    bus_stop();
    clks(5);
    check_val("rs_acks", {a1, a2}, 2'b00);
    check_val("rs_wr_cnt", wr_cnt, 2);
    check_val("rs_wr_addr", wr_addr, 6'h11);
    check_val("rs_wr_data", wr_data, 8'h7E);

    // Extra byte after the data ACK is ignored.
    bus_start();
    send_hdr(6'h01, 1'b0);
    recv_bit(a1);
    send_byte(8'h22, 8);
    recv_bit(a2);
    send_byte(8'h55, 8);
    bus_stop();
    clks(5);
    check_val("ws_wr_cnt", wr_cnt, 3);
    check_val("ws_wr_data", wr_data, 8'h22);

    // Reset during data bit 5 of a write (data AD, bit 5 is a 1).
    bus_start();
    send_hdr(6'h2F, 1'b0);
    recv_bit(a1);
    send_byte(8'hAD, 4);
    ctl_low = 1'b0;
    clks(H / 2);
    reset = 1'b0;
    clks(2);
    check_val("mr_sda", sda, 1);
    check_val("mr_busy", busy, 0);
    check_val("mr_addr", mem_addr, 0);
    check_val("mr_wdata", mem_wdata, 0);
    reset = 1'b1;
    clks(H / 2);
    scl = 1'b1; clks(H);
    scl = 1'b0; clks(2);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    recv_bit(a2);
    bus_stop();
    clks(5);
    check_val("mr_no_ack", a2, 1);
    check_val("mr_no_strobe", wr_cnt, 3);
    write_frame(6'h3C, 8'h5A, a1, a2);
    clks(5);
    check_val("mr_next_acks", {a1, a2}, 2'b00);
    check_val("mr_next_cnt", wr_cnt, 4);
    check_val("mr_next_addr", wr_addr, 6'h3C);
    check_val("mr_next_data", wr_data, 8'h5A);

    // Reset while the target is pulling the header ACK low.
    bus_start();
    send_hdr(6'h2A, 1'b0);
    ctl_low = 1'b0;
    clks(H);
    check_val("ra_ack_drive", sda, 0);
    reset = 1'b0;
    clks(1);
    check_val("ra_sda_release", sda, 1);
    reset = 1'b1;
    scl = 1'b1; clks(H);
    scl = 1'b0; clks(2);
    bus_stop();
    clks(5);
    check_val("ra_busy", busy, 0);

    // STOP in the middle of RDATA while the target outputs a 1 bit.
    rd_value = 8'h96;
    bus_start();
    send_hdr(6'h05, 1'b1);
    recv_bit(a1);
    d = 8'h00;
    for (int i = 7; i >= 5; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    check_val("sr_bits", d[7:5], 3'b100);
    check_val("sr_busy_mid", busy, 1);
    ctl_low = 1'b1; clks(H);
    scl = 1'b1;     clks(H);
    ctl_low = 1'b0; clks(STOP_LAT);
    check_val("sr_sda", sda, 1);
    check_val("sr_busy", busy, 0);
    check_val("sr_rd_cnt", rd_cnt, 2);
    clks(H);

    // One-clk low glitch on sda while scl is high.
    bc0 = busy_cyc;
    ctl_low = 1'b1; clks(1);
    ctl_low = 1'b0; clks(12);
    check_val("gl_start_seen", (busy_cyc != bc0), GLITCH_SEEN);
    check_val("gl_busy_end", busy, 0);
    check_val("gl_no_strobe", wr_cnt + rd_cnt, 6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
